// File: rtl/block_to_raster_if.sv
// Block-row in / raster-line out bus of the decoder back end.
//   in_valid/in_data/in_sob/in_eob/in_sof : one 8-pixel block row per beat
//   out_valid/out_data/out_sol/out_eol/out_sof : one 8-pixel slice of an image line
//   err : sticky protocol error flag
// master = the side that drives input beats and observes output;
// slave  = block_to_raster itself.
interface block_to_raster_if #(parameter int W = 8);
    logic              in_valid;
    logic [7:0][W-1:0] in_data;
    logic              in_sob;
    logic              in_eob;
    logic              in_sof;
    logic              out_valid;
    logic [7:0][W-1:0] out_data;
    logic              out_sol;
    logic              out_eol;
    logic              out_sof;
    logic              err;

    modport master (
        output in_valid, in_data, in_sob, in_eob, in_sof,
        input  out_valid, out_data, out_sol, out_eol, out_sof, err
    );
    modport slave (
        input  in_valid, in_data, in_sob, in_eob, in_sof,
        output out_valid, out_data, out_sol, out_eol, out_sof, err
    );
endinterface

// File: rtl/block_to_raster.sv
// block_to_raster: collects strips of BLK_PER_LINE 8x8 blocks (8 row beats each)
// into a double-buffered strip memory and replays each strip in raster order:
// 8 image lines, each BLK_PER_LINE beats of 8 pixels.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : async active-low reset (released synchronously inside)
//   bus    : block_to_raster_if.slave (block-row input, raster output, err)
module block_to_raster #(
    parameter int W            = 8,
    parameter int BLK_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    block_to_raster_if.slave      bus
);
    localparam int BW    = (BLK_PER_LINE > 1) ? $clog2(BLK_PER_LINE) : 1;
    localparam int WORDS = 16 * BLK_PER_LINE;
    localparam int AW    = $clog2(WORDS);
    localparam logic [BW-1:0] LAST = BW'(BLK_PER_LINE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    // word address of [bank][row][blk]
    function automatic logic [AW-1:0] addr(input logic bank, input logic [2:0] row,
                                           input logic [BW-1:0] blk);
        return AW'(bank) * AW'(8 * BLK_PER_LINE) + AW'(row) * AW'(BLK_PER_LINE) + AW'(blk);
    endfunction

    // reset: asserted asynchronously, released on a clock edge
    logic [1:0] rst_sync;
    logic       srst_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign srst_n = rst_sync[1];

    logic [7:0][W-1:0] mem [WORDS];

    // write side
    logic          wr_bank;
    logic [BW-1:0] wr_blk;
    logic [2:0]    wr_row;
    logic [1:0]    full;
    logic [1:0]    sof_tag;
    logic          err_q;

    // read side
    state_t            state;
    logic              rd_bank;
    logic [BW-1:0]     rd_blk;
    logic [2:0]        rd_row;
    logic              out_valid_q, out_sol_q, out_eol_q, out_sof_q;
    logic [7:0][W-1:0] out_data_q;

    logic [2:0]    eff_row;
    logic [BW-1:0] eff_blk;
    logic          rd_drain, wr_blocked, wr_en, wr_done;

    always_comb begin
        eff_row    = bus.in_sob ? 3'd0 : wr_row;
        eff_blk    = (bus.in_sob && bus.in_sof) ? '0 : wr_blk;
        rd_drain   = (state == STREAM) && (rd_row == 3'd7) && (rd_blk == LAST);
        // The bank whose last word is read this cycle may already take the first
        // word of the next strip: it lands at a different address on the same edge.
        wr_blocked = full[wr_bank] && !(rd_drain && (rd_bank == wr_bank));
        wr_en      = bus.in_valid && !wr_blocked;
        wr_done    = wr_en && (eff_row == 3'd7) && (eff_blk == LAST);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr(wr_bank, eff_row, eff_blk)] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wr_bank <= 1'b0;
            wr_blk  <= '0;
            wr_row  <= 3'd0;
            full    <= 2'b00;
            sof_tag <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            if (bus.in_valid && wr_blocked) err_q <= 1'b1;
            if (wr_en) begin
                // sob while the previous block is still open: that slot restarts
                if (bus.in_sob && (wr_row != 3'd0)) err_q <= 1'b1;
                if (bus.in_eob != (eff_row == 3'd7)) err_q <= 1'b1;
                if (bus.in_sob && (eff_blk == '0)) sof_tag[wr_bank] <= bus.in_sof;
                if (eff_row == 3'd7) begin
                    wr_row <= 3'd0;
                    if (eff_blk == LAST) begin
                        wr_blk  <= '0;
                        wr_bank <= ~wr_bank;
                    end else begin
                        wr_blk <= eff_blk + BW'(1);
                    end
                end else begin
                    // early eob: block slot is rewritten from row 0
                    wr_row <= bus.in_eob ? 3'd0 : eff_row + 3'd1;
                    wr_blk <= eff_blk;
                end
            end
            // clear before set: a set of the same bank must win
            if (rd_drain) full[rd_bank] <= 1'b0;
            if (wr_done)  full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_blk      <= '0;
            rd_row      <= 3'd0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            case (state)
                IDLE: begin
                    rd_row <= 3'd0;
                    rd_blk <= '0;
                    if (full[rd_bank]) state <= STREAM;
                end
                STREAM: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= mem[addr(rd_bank, rd_row, rd_blk)];
                    out_sol_q   <= (rd_blk == '0);
                    out_eol_q   <= (rd_blk == LAST);
                    out_sof_q   <= sof_tag[rd_bank] && (rd_row == 3'd0) && (rd_blk == '0);
                    if (rd_blk == LAST) begin
                        rd_blk <= '0;
                        if (rd_row == 3'd7) begin
                            rd_row  <= 3'd0;
                            rd_bank <= ~rd_bank;
                            // next strip ready now (or completing this edge): no gap
                            if (!(full[~rd_bank] || wr_done)) state <= IDLE;
                        end else begin
                            rd_row <= rd_row + 3'd1;
                        end
                    end else begin
                        rd_blk <= rd_blk + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sol   = out_sol_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_block_to_raster.sv
module tb_block_to_raster;
    localparam int W   = 8;
    localparam int BPL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_to_raster_if #(.W(W)) bus();
    block_to_raster #(.W(W), .BLK_PER_LINE(BPL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0][W-1:0] d;
        logic              sol;
        logic              eol;
        logic              sof;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    strip_pos = 0;
    bit    prev_end = 1'b0;
    bit    cont_mode = 1'b0;

    function automatic logic [W-1:0] pix(input int id, input int row, input int col,
                                         input logic [W-1:0] seed);
        return W'((id << 6) | (row << 3) | col) ^ seed;
    endfunction

    function automatic logic [7:0][W-1:0] row_data(input int id, input int row,
                                                   input logic [W-1:0] seed);
        logic [7:0][W-1:0] d;
        for (int c = 0; c < 8; c++) d[c] = pix(id, row, c, seed);
        return d;
    endfunction

    // expected raster beats of a strip holding block id0 at blk0 and id1 at blk1
    task automatic push_strip(input int id0, input int id1, input logic [W-1:0] seed, input bit sof);
        for (int k = 0; k < 8 * BPL; k++) begin
            beat_t e;
            int    line;
            int    b;
            line  = k / BPL;
            b     = k % BPL;
            e.d   = row_data((b == 0) ? id0 : id1, line, seed);
            e.sol = (b == 0);
            e.eol = (b == BPL - 1);
            e.sof = sof && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sob   = 1'b0;
            bus.in_eob   = 1'b0;
            bus.in_sof   = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [7:0][W-1:0] d, input bit sob, input bit eob, input bit sof);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sob   = sob;
        bus.in_eob   = eob;
        bus.in_sof   = sof;
        @(posedge clk);
    endtask

    task automatic send_rows(input int id, input logic [W-1:0] seed, input bit sof,
                             input int first, input int last, input int gapmax);
        for (int r = first; r <= last; r++) begin
            send_beat(row_data(id, r, seed), r == 0, r == 7, sof && (r == 0));
            if (gapmax > 0) idle($urandom_range(gapmax, 1));
        end
    endtask

    task automatic send_block(input int id, input logic [W-1:0] seed, input bit sof, input int gapmax);
        send_rows(id, seed, sof, 0, 7, gapmax);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_drain: observed %0d beats pending expected 0", tag, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // output monitor: scoreboard order, flags, and no gaps inside a strip
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (strip_pos != 0 || (cont_mode && prev_end && exp_q.size() != 0)) begin
                n_cmp++;
                assert (bus.out_valid === 1'b1) else begin
                    n_err++;
                    $error("FAIL out_gap: observed out_valid=%b expected 1 (pos %0d)", bus.out_valid, strip_pos);
                end
            end
            prev_end = 1'b0;
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_beat: observed out_valid=1 data=%h expected no beat", bus.out_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert ({bus.out_data, bus.out_sol, bus.out_eol, bus.out_sof} ===
                            {e.d, e.sol, e.eol, e.sof}) else begin
                        n_err++;
                        $error("FAIL beat: observed data=%h sol=%b eol=%b sof=%b expected data=%h sol=%b eol=%b sof=%b",
                               bus.out_data, bus.out_sol, bus.out_eol, bus.out_sof, e.d, e.sol, e.eol, e.sof);
                    end
                end
                strip_pos = (strip_pos + 1) % (8 * BPL);
                prev_end  = (strip_pos == 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sob   = 1'b0;
        bus.in_eob   = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n        = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sol",   bus.out_sol,   0);
        check("rst_out_eol",   bus.out_eol,   0);
        check("rst_out_sof",   bus.out_sof,   0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_err",       bus.err,       0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: one strip, contiguous, sof; output starts 2 clk after the last input beat
        push_strip(0, 1, 8'h00, 1'b1);
        send_block(0, 8'h00, 1'b1, 0);
        send_block(1, 8'h00, 1'b0, 0);
        idle(1);
        check("t1_lat_a", bus.out_valid, 0);
        @(negedge clk);
        check("t1_lat_b", bus.out_valid, 0);
        @(negedge clk);
        check("t1_lat_c", bus.out_valid, 1);
        check("t1_first_data", bus.out_data, row_data(0, 0, 8'h00));
        wait_drain("t1");
        check("t1_err", bus.err, 0);

        // 2: random gaps between rows, 6 strips
        for (int s = 0; s < 6; s++) begin
            logic [W-1:0] seed;
            seed = W'(8'h13 * (s + 1));
            push_strip(0, 1, seed, 1'b0);
            send_block(0, seed, 1'b0, 36);
            send_block(1, seed, 1'b0, 36);
        end
        idle(1);
        wait_drain("t2");
        check("t2_err", bus.err, 0);

        // 3: max rate, 10 strips, output continuous across strips
        cont_mode = 1'b1;
        for (int s = 0; s < 10; s++) begin
            logic [W-1:0] seed;
            seed = W'(8'h29 * (s + 1));
            push_strip(0, 1, seed, 1'b0);
            send_block(0, seed, 1'b0, 0);
            send_block(1, seed, 1'b0, 0);
        end
        idle(1);
        wait_drain("t3");
        cont_mode = 1'b0;
        check("t3_err", bus.err, 0);

        // 4: sof on the second block drops the partial strip
        push_strip(3, 1, 8'h5A, 1'b1);
        send_block(2, 8'h5A, 1'b0, 0);
        send_block(3, 8'h5A, 1'b1, 0);
        send_block(1, 8'h5A, 1'b0, 0);
        idle(1);
        wait_drain("t4");
        check("t4_err", bus.err, 0);

        // 5: sob at row 4 flags err; restarted block and later strips still correct
        push_strip(0, 1, 8'hA5, 1'b0);
        send_rows(0, 8'h3C, 1'b0, 0, 3, 0);
        idle(1);
        check("t5_err_before", bus.err, 0);
        send_block(0, 8'hA5, 1'b0, 0);
        idle(1);
        check("t5_err_set", bus.err, 1);
        send_block(1, 8'hA5, 1'b0, 0);
        idle(1);
        wait_drain("t5a");
        push_strip(1, 0, 8'h77, 1'b0);
        send_block(1, 8'h77, 1'b0, 0);
        send_block(0, 8'h77, 1'b0, 0);
        idle(1);
        wait_drain("t5b");
        check("t5_err_sticky", bus.err, 1);

        // 6: reset 3 rows into blk1 discards the partial strip
        send_block(0, 8'hE1, 1'b0, 0);
        send_rows(1, 8'hE1, 1'b0, 0, 2, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sob   = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_err",   bus.err,       0);
        check("t6_rst_sol",   bus.out_sol,   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        check("t6_no_output", bus.out_valid, 0);
        push_strip(2, 3, 8'hC3, 1'b1);
        send_block(2, 8'hC3, 1'b1, 0);
        send_block(3, 8'hC3, 1'b0, 0);
        idle(1);
        wait_drain("t6");
        check("t6_err", bus.err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
